// File: rtl/tlda_pkg.sv
// Shared types, widths and the pixel-address helper for the TLDA line engine.
package tlda_pkg;

  localparam int COORD_W = 9;   // working coordinate width (x and swapped y)
  localparam int YIN_W   = 8;   // endpoint y width at the register interface
  localparam int ERR_W   = 11;  // signed Bresenham error accumulator
  localparam int COLOR_W = 16;  // RGB565
  localparam int THICK_W = 9;

  localparam int          SCREEN_W_DEF    = 320;
  localparam int          SCREEN_H_DEF    = 240;
  localparam logic [31:0] BUFFER_BASE_DEF = 32'h0800_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PLOT,
    S_ADVANCE
  } state_t;

  // Rows are 1024 bytes apart; each pixel is two bytes.
  function automatic logic [31:0] pixel_addr(input logic [31:0]      base,
                                             input logic [COORD_W:0] xs,
                                             input logic [COORD_W:0] ys);
    return base + ({22'd0, ys} << 10) + ({22'd0, xs} << 1);
  endfunction

endpackage

// File: rtl/tlda_pixel_writer.sv
// Avalon-MM single-beat write master: holds address/data/write until the
// slave drops waitrequest, and reports the accepting cycle.
module tlda_pixel_writer
  import tlda_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [31:0]        addr,
  input  logic [COLOR_W-1:0] data,
  output logic [31:0]        master_address,
  output logic               master_write,
  output logic [COLOR_W-1:0] master_writedata,
  output logic [1:0]         master_byteenable,
  input  logic               master_waitrequest,
  output logic               accepted
);

  assign master_byteenable = 2'b11;
  assign accepted          = master_write & ~master_waitrequest;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
    end else if (start) begin
      master_write     <= 1'b1;
      master_address   <= addr;
      master_writedata <= data;
    end else if (accepted) begin
      master_write <= 1'b0;
    end
  end

endmodule

// File: rtl/tlda_line_engine.sv
// Bresenham line engine writing RGB565 pixels over Avalon-MM.
// Optional wide lines: define TLDA_THICKNESS_EN.
module tlda_line_engine
  import tlda_pkg::*;
#(
  parameter int          SCREEN_W    = SCREEN_W_DEF,
  parameter int          SCREEN_H    = SCREEN_H_DEF,
  parameter logic [31:0] BUFFER_BASE = BUFFER_BASE_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                Go,
  input  logic [COORD_W-1:0]  X0,
  input  logic [COORD_W-1:0]  X1,
  input  logic [YIN_W-1:0]    Y0,
  input  logic [YIN_W-1:0]    Y1,
  input  logic [COLOR_W-1:0]  Color,
  input  logic [THICK_W-1:0]  Thickness,
  output logic                Done,
  output logic [31:0]         master_address,
  output logic                master_write,
  output logic [COLOR_W-1:0]  master_writedata,
  output logic [1:0]          master_byteenable,
  input  logic                master_waitrequest
);

  localparam logic [COORD_W:0] SCR_W_L = SCREEN_W[COORD_W:0];
  localparam logic [COORD_W:0] SCR_H_L = SCREEN_H[COORD_W:0];

  state_t state_q, state_d;

  // Latched command
  logic [COORD_W-1:0] x0_q, x1_q;
  logic [YIN_W-1:0]   y0_q, y1_q;
  logic [COLOR_W-1:0] color_q;

  // Working Bresenham state, in the (possibly swapped) major/minor frame
  logic [COORD_W-1:0]      x_q, y_q, x_end_q, dx_q, dy_q;
  logic signed [ERR_W-1:0] err_q;
  logic                    steep_q, ystep_neg_q;

  // Setup-stage combinational results
  logic [COORD_W-1:0]      ey0, ey1, adx, ady;
  logic [COORD_W-1:0]      px0, py0, px1, py1, sx0, sy0, sx1, sy1;
  logic [COORD_W-1:0]      dx_c, dy_c;
  logic                    steep_c, ystep_neg_c;
  logic signed [ERR_W-1:0] err_init_c;

  // Advance-stage combinational results
  logic signed [ERR_W-1:0] err_sum, err_next;
  logic [COORD_W-1:0]      y_next;

  // Screen-space pixel
  logic [COORD_W:0] offset, xs, ys;
  logic             on_screen, last_layer, pix_done;
  logic             start_write, accepted;

  assign ey0 = {1'b0, y0_q};
  assign ey1 = {1'b0, y1_q};

  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else); a missed assignment would infer a latch.
  always_comb begin
    adx     = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
    ady     = (ey1 >= ey0) ? ey1 - ey0 : ey0 - ey1;
    steep_c = ady > adx;
    px0     = steep_c ? ey0  : x0_q;
    py0     = steep_c ? x0_q : ey0;
    px1     = steep_c ? ey1  : x1_q;
    py1     = steep_c ? x1_q : ey1;
    if (px0 > px1) begin
      sx0 = px1; sy0 = py1; sx1 = px0; sy1 = py0;
    end else begin
      sx0 = px0; sy0 = py0; sx1 = px1; sy1 = py1;
    end
    dx_c        = sx1 - sx0;
    dy_c        = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
    ystep_neg_c = !(sy0 < sy1);
    err_init_c  = $signed({(ERR_W-COORD_W+1){1'b0}}) -
                  $signed({{(ERR_W-COORD_W+1){1'b0}}, dx_c[COORD_W-1:1]});
  end

  always_comb begin
    err_sum  = err_q + $signed({{(ERR_W-COORD_W){1'b0}}, dy_q});
    err_next = err_sum;
    y_next   = y_q;
    if (err_sum >= 0) begin
      err_next = err_sum - $signed({{(ERR_W-COORD_W){1'b0}}, dx_q});
      y_next   = ystep_neg_q ? y_q - 1'b1 : y_q + 1'b1;
    end
  end

`ifdef TLDA_THICKNESS_EN
  logic [THICK_W-1:0] thick_q, layer_q, layer_last;

  assign offset     = {1'b0, layer_q};
  assign layer_last = (thick_q == '0) ? '0 : thick_q - 1'b1;
  assign last_layer = (layer_q == layer_last);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thick_q <= '0;
      layer_q <= '0;
    end else begin
      if (state_q == S_IDLE && Go) thick_q <= Thickness;
      if (state_q == S_SETUP) begin
        layer_q <= '0;
      end else if (state_q == S_PLOT && pix_done) begin
        layer_q <= last_layer ? '0 : layer_q + 1'b1;
      end
    end
  end
`else
  logic unused_thickness;

  assign unused_thickness = ^Thickness;
  assign offset           = '0;
  assign last_layer       = 1'b1;
`endif

  // Thickness grows along the minor screen axis: +y when shallow, +x when steep.
  assign xs        = {1'b0, (steep_q ? y_q : x_q)} + (steep_q ? offset : '0);
  assign ys        = {1'b0, (steep_q ? x_q : y_q)} + (steep_q ? '0 : offset);
  assign on_screen = (xs < SCR_W_L) && (ys < SCR_H_L);
  assign pix_done  = on_screen ? accepted : 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_write = 1'b0;
    case (state_q)
      S_IDLE:  if (Go) state_d = S_SETUP;
      S_SETUP: state_d = S_PLOT;
      S_PLOT: begin
        start_write = on_screen && !master_write;
        if (pix_done && last_layer) state_d = S_ADVANCE;
      end
      S_ADVANCE: state_d = (x_q == x_end_q) ? S_IDLE : S_PLOT;
      default: state_d = S_IDLE;
    endcase
  end

  assign Done = (state_q == S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_end_q     <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      steep_q     <= 1'b0;
      ystep_neg_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Go) begin
          x0_q    <= X0;
          x1_q    <= X1;
          y0_q    <= Y0;
          y1_q    <= Y1;
          color_q <= Color;
        end
        S_SETUP: begin
          x_q         <= sx0;
          y_q         <= sy0;
          x_end_q     <= sx1;
          dx_q        <= dx_c;
          dy_q        <= dy_c;
          err_q       <= err_init_c;
          steep_q     <= steep_c;
          ystep_neg_q <= ystep_neg_c;
        end
        S_ADVANCE: if (x_q != x_end_q) begin
          x_q   <= x_q + 1'b1;
          y_q   <= y_next;
          err_q <= err_next;
        end
        default: ;
      endcase
    end
  end

  tlda_pixel_writer u_writer (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start_write),
    .addr               (pixel_addr(BUFFER_BASE, xs, ys)),
    .data               (color_q),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_byteenable  (master_byteenable),
    .master_waitrequest (master_waitrequest),
    .accepted           (accepted)
  );

endmodule

// File: tb/tb_tlda_line_engine.sv
// Scoreboard bench for tlda_line_engine: a reference line rasteriser queues the
// expected pixel writes, a monitor pops and compares every accepted write.
module tb_tlda_line_engine;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        Go = 1'b0;
  logic [8:0]  X0 = '0, X1 = '0;
  logic [7:0]  Y0 = '0, Y1 = '0;
  logic [15:0] Color = '0;
  logic [8:0]  Thickness = '0;
  logic        Done;
  logic [31:0] master_address;
  logic        master_write;
  logic [15:0] master_writedata;
  logic [1:0]  master_byteenable;
  logic        master_waitrequest = 1'b0;

  tlda_line_engine dut (
    .clk                (clk),
    .resetn             (resetn),
    .Go                 (Go),
    .X0                 (X0),
    .X1                 (X1),
    .Y0                 (Y0),
    .Y1                 (Y1),
    .Color              (Color),
    .Thickness          (Thickness),
    .Done               (Done),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_byteenable  (master_byteenable),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  writes_seen = 0;
  int  wr_mode = 0;  // 0: never stall, 1: random stalls, 2: stall 3 cycles per write

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [31:0] addr_of(int xs, int ys);
    return 32'h0800_0000 + 32'(ys * 1024 + xs * 2);
  endfunction

  function automatic void push_px(int xs, int ys, logic [15:0] c);
    if (xs < 320 && ys < 240) exp_q.push_back('{addr_of(xs, ys), c});
  endfunction

  // Reference rasteriser: classic Bresenham on integers, optional thickness.
  function automatic void model_line(int ax, int ay, int bx, int by, logic [15:0] c, int th);
    int t, dx, dy, ystep, err, y, tmp;
    bit steep;
`ifdef TLDA_THICKNESS_EN
    t = (th < 1) ? 1 : th;
`else
    t = 1;
`endif
    steep = iabs(by - ay) > iabs(bx - ax);
    if (steep) begin
      tmp = ax; ax = ay; ay = tmp;
      tmp = bx; bx = by; by = tmp;
    end
    if (ax > bx) begin
      tmp = ax; ax = bx; bx = tmp;
      tmp = ay; ay = by; by = tmp;
    end
    dx = bx - ax;
    dy = iabs(by - ay);
    ystep = (ay < by) ? 1 : -1;
    err = -(dx / 2);
    y = ay;
    for (int x = ax; x <= bx; x++) begin
      for (int k = 0; k < t; k++) begin
        if (steep) push_px(y + k, x, c);
        else       push_px(x, y + k, c);
      end
      err += dy;
      if (err >= 0) begin
        y += ystep;
        err -= dx;
      end
    end
  endfunction

  // Waitrequest generator
  initial begin
    int stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (wr_mode)
        1: master_waitrequest = 1'($urandom_range(1, 0));
        2: begin
          if (master_write && stall_cnt < 3) begin
            master_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            master_waitrequest = 1'b0;
            stall_cnt = 0;
          end
        end
        default: master_waitrequest = 1'b0;
      endcase
    end
  end

  // Monitor: compares each accepted write and checks hold-stability during stalls.
  initial begin
    bit          hold_v = 1'b0;
    logic [31:0] hold_a;
    logic [15:0] hold_d;
    wr_t         e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        hold_v = 1'b0;
      end else if (master_write) begin
        if (hold_v) begin
          check("stall_addr_stable", master_address, hold_a);
          check("stall_data_stable", {16'd0, master_writedata}, {16'd0, hold_d});
        end
        if (master_waitrequest) begin
          hold_v = 1'b1;
          hold_a = master_address;
          hold_d = master_writedata;
        end else begin
          hold_v = 1'b0;
          writes_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%04h, none expected",
                     master_address, master_writedata);
          end else begin
            e = exp_q.pop_front();
            check("write_addr", master_address, e.addr);
            check("write_data", {16'd0, master_writedata}, {16'd0, e.data});
            check("byteenable", {30'd0, master_byteenable}, 32'd3);
          end
        end
      end else begin
        if (hold_v) check("write_held_during_stall", {31'd0, master_write}, 32'd1);
        hold_v = 1'b0;
      end
    end
  end

  task automatic pulse_go(int ax, int ay, int bx, int by, logic [15:0] c, int th,
                          output int wb);
    @(posedge clk);
    #1;
    X0 = 9'(ax); Y0 = 8'(ay); X1 = 9'(bx); Y1 = 8'(by);
    Color = c; Thickness = 9'(th);
    wb = writes_seen;
    Go = 1'b1;
    @(posedge clk);
    #1;
    Go = 1'b0;
    check("done_low_after_go", {31'd0, Done}, 32'd0);
    X0 = 9'($urandom); Y0 = 8'($urandom); X1 = 9'($urandom); Y1 = 8'($urandom);
    Color = 16'($urandom); Thickness = 9'($urandom);
  endtask

  // Waits for Done (bounded), optionally firing stray Go pulses; cycles counts
  // edges after the Go-sampling edge.
  task automatic finish_line(int nexp, int wb, bit spam, int start_cyc, output int cycles);
    cycles = start_cyc;
    while (!Done && cycles < 20000) begin
      if (spam && (cycles % 5) == 2) begin
        X0 = 9'($urandom_range(300, 0)); Y0 = 8'($urandom_range(200, 0));
        X1 = 9'($urandom_range(300, 0)); Y1 = 8'($urandom_range(200, 0));
        Go = 1'b1;
      end else begin
        Go = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    Go = 1'b0;
    check("done_before_timeout", {31'd0, Done}, 32'd1);
    check("write_count", 32'(writes_seen - wb), 32'(nexp));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_line(int ax, int ay, int bx, int by, logic [15:0] c, int th, bit spam);
    int n0, wb, cyc;
    n0 = exp_q.size();
    model_line(ax, ay, bx, by, c, th);
    pulse_go(ax, ay, bx, by, c, th, wb);
    finish_line(exp_q.size() - n0, wb, spam, 0, cyc);
  endtask

  initial begin
    int wb, cyc, n0;
    int ax, ay, bx, by;

    // Reset state
    #12;
    check("reset_done", {31'd0, Done}, 32'd1);
    check("reset_write", {31'd0, master_write}, 32'd0);
    check("reset_addr", master_address, 32'd0);
    check("reset_data", {16'd0, master_writedata}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_writes", 32'(writes_seen), 32'd0);

    // Horizontal line with latency check
    wr_mode = 0;
    n0 = exp_q.size();
    for (int x = 10; x <= 13; x++) exp_q.push_back('{32'h0800_1400 + 32'(2 * x), 16'hF800});
    pulse_go(10, 5, 13, 5, 16'hF800, 1, wb);
    check("write_low_after_N", {31'd0, master_write}, 32'd0);
    @(posedge clk);
    #1;
    check("write_low_after_N1", {31'd0, master_write}, 32'd1 - 32'd1);
    @(posedge clk);
    #1;
    check("write_high_after_N2", {31'd0, master_write}, 32'd1);
    check("first_addr", master_address, 32'h0800_1414);
    finish_line(exp_q.size() - n0, wb, 1'b0, 2, cyc);
    check("hline_cycles", 32'(cyc), 32'd13);

    // Steep line forward and reversed: fixed pixel list
    for (int r = 0; r < 2; r++) begin
      n0 = exp_q.size();
      exp_q.push_back('{addr_of(0, 0), 16'h07E0});
      exp_q.push_back('{addr_of(0, 1), 16'h07E0});
      exp_q.push_back('{addr_of(1, 2), 16'h07E0});
      exp_q.push_back('{addr_of(1, 3), 16'h07E0});
      exp_q.push_back('{addr_of(1, 4), 16'h07E0});
      exp_q.push_back('{addr_of(2, 5), 16'h07E0});
      exp_q.push_back('{addr_of(2, 6), 16'h07E0});
      if (r == 0) pulse_go(0, 0, 2, 6, 16'h07E0, 1, wb);
      else        pulse_go(2, 6, 0, 0, 16'h07E0, 1, wb);
      finish_line(exp_q.size() - n0, wb, 1'b0, 0, cyc);
    end

    // Stalled writes with stray Go pulses while busy
    wr_mode = 2;
    run_line(20, 30, 27, 33, 16'h001F, 1, 1'b1);
    run_line(40, 50, 36, 58, 16'hABCD, 2, 1'b1);
    wr_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    check("no_restart_after_spam", {31'd0, Done}, 32'd1);

    // Right-edge clipping
    n0 = exp_q.size();
    exp_q.push_back('{addr_of(318, 10), 16'h1234});
    exp_q.push_back('{addr_of(319, 10), 16'h1234});
    pulse_go(318, 10, 322, 10, 16'h1234, 1, wb);
    finish_line(exp_q.size() - n0, wb, 1'b0, 0, cyc);
    check("clip_cycles", 32'(cyc), 32'd13);

    // Point lines and thickness
    n0 = exp_q.size();
    exp_q.push_back('{addr_of(50, 60), 16'h5555});
`ifdef TLDA_THICKNESS_EN
    exp_q.push_back('{addr_of(50, 61), 16'h5555});
    exp_q.push_back('{addr_of(50, 62), 16'h5555});
`endif
    pulse_go(50, 60, 50, 60, 16'h5555, 3, wb);
    finish_line(exp_q.size() - n0, wb, 1'b0, 0, cyc);
    n0 = exp_q.size();
    exp_q.push_back('{addr_of(50, 60), 16'hAAAA});
    pulse_go(50, 60, 50, 60, 16'hAAAA, 0, wb);
    finish_line(exp_q.size() - n0, wb, 1'b0, 0, cyc);

    // Randomised lines against the reference rasteriser
    for (int i = 0; i < 14; i++) begin
      ax = $urandom_range(340, 0);
      ay = $urandom_range(250, 0);
      bx = $urandom_range(ax + 30, (ax > 30) ? ax - 30 : 0);
      by = $urandom_range((ay + 30 > 255) ? 255 : ay + 30, (ay > 30) ? ay - 30 : 0);
      wr_mode = $urandom_range(2, 0);
      run_line(ax, ay, bx, by, 16'($urandom), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    // Reset in the middle of a line
    wr_mode = 0;
    model_line(0, 100, 300, 120, 16'hFFFF, 1);
    pulse_go(0, 100, 300, 120, 16'hFFFF, 1, wb);
    repeat (40) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("midreset_done", {31'd0, Done}, 32'd1);
    check("midreset_write", {31'd0, master_write}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    wb = writes_seen;
    repeat (20) @(posedge clk);
    #1;
    check("no_resume_writes", 32'(writes_seen - wb), 32'd0);
    check("no_resume_done", {31'd0, Done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
